vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Consumes the one-clk_in-cycle pixel-rate tick from the clock divider (25 MHz tick from 100 MHz) and generates VGA 640x480@60 raster timing.
- Outputs: hsync, vsync, active-video flag, current pixel coordinates and line/frame start strobes.
- Sits between the divider and the game renderer/colour mux.
- The whole block runs on clk_in; pix_en is a clock enable, never a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse (0 = active-low)
- CW, 10, width of the coordinate counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_in  input  1  system clock (100 MHz)
- reset_n  input  1  reset, synchronous, active-low
- pix_en  input  1  pixel tick from the clock divider; one clk_in cycle wide
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while the current pixel is in the visible area
- pixel_x  output  CW  current horizontal count, 0..H_TOTAL-1
- pixel_y  output  CW  current vertical count, 0..V_TOTAL-1
- line_start  output  1  one clk_in-cycle strobe when pixel_x wraps to 0
- frame_start  output  1  one clk_in-cycle strobe when (pixel_x, pixel_y) wraps to (0,0)

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Reset: sampled on a rising clk_in edge with reset_n=0; overrides pix_en. Reset state:
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1 (parked at the last blanking pixel)
  - hsync = vsync = !SYNC_ACTIVE
  - video_on = 0, line_start = 0, frame_start = 0
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1
- First pix_en after reset wraps to (0,0) and fires frame_start, so every frame is complete from pixel 0.
- Counters advance only on edges where pix_en=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1 with h_cnt at H_TOTAL-1, v_cnt wraps to 0.
  - With pix_en=0, all counters and level outputs hold.
- Output timing:
  - All outputs are registered.
  - They change on the same edge as the counters and always describe the new (h_cnt, v_cnt).
  - Latency from a pix_en cycle to updated outputs is one clk_in edge.
- Horizontal phase FSM (ACTIVE, FP, SYNC, BP), decoded from h_cnt:
  - ACTIVE: 0..639
  - FP: 640..655
  - SYNC: 656..751
  - BP: 752..799
- Vertical phase FSM (same states), decoded from v_cnt:
  - ACTIVE: 0..479
  - FP: 480..489
  - SYNC: 490..491
  - BP: 492..524
- hsync = SYNC_ACTIVE iff the H phase is SYNC; vsync = SYNC_ACTIVE iff the V phase is SYNC. vsync is line-aligned and toggles on the edge where h_cnt wraps to 0.
- video_on = (H phase ACTIVE) && (V phase ACTIVE).
- pixel_x/pixel_y: raw counter values, not clipped during blanking. The renderer must qualify them with video_on.
- line_start: high for exactly one clk_in cycle following the pix_en edge that sets h_cnt to 0; low otherwise, including while pix_en is low.
- frame_start: high for exactly one clk_in cycle following the pix_en edge that sets both counters to 0. frame_start implies line_start in the same cycle.
- pix_en held high continuously is legal: timing advances one pixel per clk_in cycle (simulation speed-up).
- Reset asserted mid-frame: the next edge returns to the reset state. No partial sync pulse is extended; hsync/vsync go inactive immediately.

Test Plan:
- Reset, then one pix_en -> pixel_x=0, pixel_y=0, video_on=1, frame_start=1 and line_start=1 for one cycle, hsync=vsync=1.
- pix_en every 4th clk_in, count ticks from a line start -> hsync falls at pixel_x=656, rises at pixel_x=752 (96 ticks low); video_on falls at pixel_x=640; line period = 800 ticks = 3200 clk_in.
- Run a full frame -> vsync low exactly for pixel_y=490..491 (1600 ticks); video_on high for 640x480=307200 ticks; frame_start period = 420000 ticks; pixel_y never exceeds 524.
- Hold pix_en=0 for 50 cycles mid-line at pixel_x=300 -> all outputs frozen, no strobes; resume -> pixel_x=301.
- Assert reset_n=0 for 1 cycle during vsync (pixel_y=491) -> next cycle vsync=1, hsync=1, video_on=0, pixel_x=799, pixel_y=524; next pix_en gives frame_start.
- pix_en tied high -> line_start every 800 clk_in cycles, frame_start every 420000 cycles, each exactly one cycle wide.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, active-video flag, line/frame strobes.
// Latency: every output is registered and changes one clk_in edge after the pix_en cycle that advances it.
// Backpressure: none; pix_en is a clock enable, and with pix_en low all counters and levels hold.
//
// Ports:
//   clk_in, reset_n (synchronous, active-low), pix_en (one-cycle pixel tick)
//   hsync, vsync      sync outputs, level SYNC_ACTIVE during the pulse
//   video_on          current pixel is inside the visible area
//   pixel_x, pixel_y  raw counters, not clipped in blanking; qualify with video_on
//   line_start        one-cycle strobe when pixel_x wraps to 0
//   frame_start       one-cycle strobe when (pixel_x, pixel_y) wraps to (0,0)
// All porch and sync widths must be non-zero so every phase is visited in order.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int CW          = 10
) (
    input  logic          clk_in,
    input  logic          reset_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_FP_START   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_BP_START   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_FP_START   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_BP_START   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_LVL = (SYNC_ACTIVE != 0);

    // Phase encoding shared by the horizontal and vertical FSMs.
    localparam logic [1:0] PH_ACTIVE = 2'd0;
    localparam logic [1:0] PH_FP     = 2'd1;
    localparam logic [1:0] PH_SYNC   = 2'd2;
    localparam logic [1:0] PH_BP     = 2'd3;

    // Phases advance in a fixed ring; each transition fires when the new count
    // lands on the first value of the next phase. For the vertical FSM the count
    // only moves on line wrap, so an unchanged count never matches the next boundary.
    function automatic logic [1:0] next_phase(
        input logic [1:0]    cur,
        input logic [CW-1:0] cnt,
        input logic [CW-1:0] fp_start,
        input logic [CW-1:0] sync_start,
        input logic [CW-1:0] bp_start
    );
        logic [1:0] nxt;
        nxt = cur;
        case (cur)
            PH_ACTIVE: if (cnt == fp_start)   nxt = PH_FP;
            PH_FP:     if (cnt == sync_start) nxt = PH_SYNC;
            PH_SYNC:   if (cnt == bp_start)   nxt = PH_BP;
            PH_BP:     if (cnt == '0)         nxt = PH_ACTIVE;
            default:                          nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]    h_phase_q, h_phase_d;
    logic [1:0]    v_phase_q, v_phase_d;
    logic          hsync_q, vsync_q, video_on_q;
    logic          line_start_q, frame_start_q;
    logic          h_wrap, v_wrap;

    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
        h_phase_d = next_phase(h_phase_q, h_cnt_d, H_FP_START, H_SYNC_START, H_BP_START);
        v_phase_d = next_phase(v_phase_q, v_cnt_d, V_FP_START, V_SYNC_START, V_BP_START);
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            // Park on the last blanking pixel so the first tick starts a whole frame.
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            h_phase_q     <= PH_BP;
            v_phase_q     <= PH_BP;
            hsync_q       <= ~SYNC_LVL;
            vsync_q       <= ~SYNC_LVL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // Strobes are rewritten every cycle so they stay one clk_in wide.
            line_start_q  <= pix_en & h_wrap;
            frame_start_q <= pix_en & h_wrap & v_wrap;
            if (pix_en) begin
                h_cnt_q    <= h_cnt_d;
                v_cnt_q    <= v_cnt_d;
                h_phase_q  <= h_phase_d;
                v_phase_q  <= v_phase_d;
                hsync_q    <= (h_phase_d == PH_SYNC) ? SYNC_LVL : ~SYNC_LVL;
                vsync_q    <= (v_phase_d == PH_SYNC) ? SYNC_LVL : ~SYNC_LVL;
                video_on_q <= (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
